id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection. It captures the 8-bit control bundle from the decode-stage control unit, plus register operands, immediate and register addresses, and presents them to EX one cycle later. It detects a load in EX whose destination matches a source of the instruction in ID. On that condition it stalls PC and IF/ID and injects a bubble into EX. It also squashes the ID instruction on a branch flush and keeps a saturating bubble counter.

---
 rtl/id_ex_stage_pkg.sv | 13 +
 rtl/id_ex_stage_hazard_detect.sv | 17 +
 rtl/id_ex_stage.sv | 65 ++++++
 tb/tb_id_ex_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// pipe_pkg: shared control-bundle bit positions and widths for decode and ID/EX
package pipe_pkg;
  localparam int CTRL_W = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_REGDST = 0;
  localparam logic [CTRL_W-1:0] CTRL_NOP = 8'h00;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use detection between EX load and ID sources, flush overrides stall
module hazard_detect (
  input  logic       ex_memread,
  input  logic       ex_valid,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       flush,
  output logic       hz,
  output logic       stall
);
  // a load into $0 never produces a value worth waiting for
  always_comb begin
    hz = ex_memread && ex_valid && ex_rt != 5'd0 && (ex_rt == id_rs || ex_rt == id_rt);
    stall = hz && !flush;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, flush squash and bubble counter
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int BUB_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [31:0]       rs_data_i,
  input  logic [31:0]       rt_data_i,
  input  logic [15:0]       imm_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [31:0]       rs_data_o,
  output logic [31:0]       rt_data_o,
  output logic [31:0]       imm_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic [BUB_W-1:0]  bub_cnt_o
);
  logic hz;
  logic bubble;
  hazard_detect u_hazard (
    .ex_memread(ctrl_o[CTRL_MEMREAD]),
    .ex_valid  (valid_o),
    .ex_rt     (rt_o),
    .id_rs     (rs_i),
    .id_rt     (rt_i),
    .flush     (flush_i),
    .hz        (hz),
    .stall     (stall_o)
  );
  assign bubble = hz || flush_i;
  // capture ID into EX; a bubble zeroes control and validity but data still flows
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_o <= CTRL_NOP;
      valid_o <= 1'b0;
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o <= '0;
      rs_o <= '0;
      rt_o <= '0;
      rd_o <= '0;
      bub_cnt_o <= '0;
    end else begin
      ctrl_o <= bubble ? CTRL_NOP : ctrl_i;
      valid_o <= !bubble;
      rs_data_o <= rs_data_i;
      rt_data_o <= rt_data_i;
      imm_o <= {{16{imm_i[15]}}, imm_i};
      rs_o <= rs_i;
      rt_o <= rt_i;
      rd_o <= rd_i;
      if (bubble && !(&bub_cnt_o)) bub_cnt_o <= bub_cnt_o + BUB_W'(1);
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table with scoreboard queue plus flush saturation and reset-mid-stall sequences
module tb_id_ex_stage;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  ctrl_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic [15:0] imm_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic        flush_i;
  logic [7:0]  ctrl_o, ctrl4;
  logic [31:0] rs_data_o, rt_data_o, imm_o, rs_data4, rt_data4, imm4;
  logic [4:0]  rs_o, rt_o, rd_o, rs4, rt4, rd4;
  logic        valid_o, stall_o, valid4, stall4;
  logic [15:0] bub_cnt_o;
  logic [3:0]  bub4;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] a, b;
    logic        flush;
    logic        stall;
    logic [7:0]  ectrl;
    logic        evalid;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[12];
  vec_t sb[$];

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i),
    .ctrl_o(ctrl_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .valid_o(valid_o), .stall_o(stall_o), .bub_cnt_o(bub_cnt_o)
  );

  id_ex_stage #(.BUB_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i),
    .ctrl_o(ctrl4), .rs_data_o(rs_data4), .rt_data_o(rt_data4), .imm_o(imm4),
    .rs_o(rs4), .rt_o(rt4), .rd_o(rd4), .valid_o(valid4), .stall_o(stall4), .bub_cnt_o(bub4)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    ctrl_i = v.ctrl;
    rs_i = v.rs;
    rt_i = v.rt;
    rd_i = v.rd;
    imm_i = v.imm;
    rs_data_i = v.a;
    rt_data_i = v.b;
    flush_i = v.flush;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    drive(v);
    #4;
    chk("stall", {31'd0, stall_o}, {31'd0, v.stall});
    chk("stall4", {31'd0, stall4}, {31'd0, v.stall});
    sb.push_back(v);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk("ctrl", {24'd0, ctrl_o}, {24'd0, e.ectrl});
    chk("valid", {31'd0, valid_o}, {31'd0, e.evalid});
    chk("bub_cnt", {16'd0, bub_cnt_o}, {16'd0, e.ecnt});
    chk("bub_cnt4", {28'd0, bub4}, e.ecnt > 16'd15 ? 32'hF : {28'd0, e.ecnt[3:0]});
    if (e.evalid) begin
      chk("rs_data", rs_data_o, e.a);
      chk("rt_data", rt_data_o, e.b);
      chk("imm", imm_o, {{16{e.imm[15]}}, e.imm});
      chk("rs", {27'd0, rs_o}, {27'd0, e.rs});
      chk("rt", {27'd0, rt_o}, {27'd0, e.rt});
      chk("rd", {27'd0, rd_o}, {27'd0, e.rd});
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_ctrl"}, {24'd0, ctrl_o}, 32'd0);
    chk({n, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({n, "_stall"}, {31'd0, stall_o}, 32'd0);
    chk({n, "_rs_data"}, rs_data_o, 32'd0);
    chk({n, "_rt_data"}, rt_data_o, 32'd0);
    chk({n, "_imm"}, imm_o, 32'd0);
    chk({n, "_regs"}, {17'd0, rs_o, rt_o, rd_o}, 32'd0);
    chk({n, "_cnt"}, {16'd0, bub_cnt_o}, 32'd0);
    chk({n, "_cnt4"}, {28'd0, bub4}, 32'd0);
  endtask

  initial begin
    logic [15:0] c16;
    logic [3:0] c4;
    tbl[0]  = '{8'h85, 5'd1, 5'd2, 5'd3, 16'h8004, 32'hA5A5_0001, 32'h0000_0002, 1'b0, 1'b0, 8'h85, 1'b1, 16'd0};
    tbl[1]  = '{8'hE8, 5'd1, 5'd5, 5'd0, 16'h0010, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 8'hE8, 1'b1, 16'd0};
    tbl[2]  = '{8'h85, 5'd5, 5'd6, 5'd7, 16'h0001, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 8'h00, 1'b0, 16'd1};
    tbl[3]  = '{8'h85, 5'd5, 5'd6, 5'd7, 16'h0001, 32'h3333_3333, 32'h2222_2222, 1'b0, 1'b0, 8'h85, 1'b1, 16'd1};
    tbl[4]  = '{8'hE8, 5'd2, 5'd0, 5'd0, 16'hFFFC, 32'h0000_2000, 32'h0, 1'b0, 1'b0, 8'hE8, 1'b1, 16'd1};
    tbl[5]  = '{8'h85, 5'd0, 5'd0, 5'd4, 16'h0000, 32'h0, 32'h0, 1'b0, 1'b0, 8'h85, 1'b1, 16'd1};
    tbl[6]  = '{8'hE8, 5'd3, 5'd9, 5'd0, 16'h7FFF, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 8'hE8, 1'b1, 16'd1};
    tbl[7]  = '{8'h85, 5'd4, 5'd9, 5'd8, 16'h0002, 32'h4, 32'h9, 1'b1, 1'b0, 8'h00, 1'b0, 16'd2};
    tbl[8]  = '{8'hFF, 5'd9, 5'd9, 5'd9, 16'h1234, 32'h5555_AAAA, 32'h0F0F_F0F0, 1'b0, 1'b0, 8'hFF, 1'b1, 16'd2};
    tbl[9]  = '{8'h85, 5'd1, 5'd9, 5'd10, 16'h0003, 32'h1, 32'h2, 1'b0, 1'b1, 8'h00, 1'b0, 16'd3};
    tbl[10] = '{8'h85, 5'd1, 5'd9, 5'd10, 16'h0003, 32'h1, 32'h2, 1'b0, 1'b0, 8'h85, 1'b1, 16'd3};
    tbl[11] = '{8'h18, 5'd2, 5'd3, 5'd0, 16'h0008, 32'h7, 32'h8, 1'b1, 1'b0, 8'h00, 1'b0, 16'd4};

    rst_i = 1'b1;
    drive(tbl[8]);
    #2;
    chk_zero("por");
    @(posedge clk_i);
    #1;
    chk_zero("por_edge");
    rst_i = 1'b0;

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    c16 = 16'd4;
    c4 = 4'd4;
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i % 12]);
      flush_i = 1'b1;
      #4;
      chk("sat_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk_i);
      #1;
      c16 = c16 + 16'd1;
      c4 = (c4 == 4'hF) ? 4'hF : c4 + 4'd1;
      chk("sat_cnt", {16'd0, bub_cnt_o}, {16'd0, c16});
      chk("sat_cnt4", {28'd0, bub4}, {28'd0, c4});
      chk("sat_valid", {31'd0, valid_o}, 32'd0);
      chk("sat_ctrl", {24'd0, ctrl_o}, 32'd0);
    end

    apply('{8'hE8, 5'd1, 5'd5, 5'd0, 16'h0000, 32'h0, 32'h0, 1'b0, 1'b0, 8'hE8, 1'b1, 16'd24});
    drive('{8'h85, 5'd5, 5'd6, 5'd7, 16'h0001, 32'h1, 32'h2, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0});
    #4;
    chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(posedge clk_i);
    #1;
    chk_zero("mid_rst_edge");
    rst_i = 1'b0;
    apply('{8'h85, 5'd5, 5'd6, 5'd7, 16'hC000, 32'hCAFE_0001, 32'h0000_BEEF, 1'b0, 1'b0, 8'h85, 1'b1, 16'd0});
    apply('{8'hE8, 5'd1, 5'd5, 5'd0, 16'h0000, 32'h0, 32'h0, 1'b0, 1'b0, 8'hE8, 1'b1, 16'd0});
    apply('{8'h85, 5'd2, 5'd5, 5'd3, 16'h0000, 32'h0, 32'h0, 1'b0, 1'b1, 8'h00, 1'b0, 16'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
